// File: rtl/linebuf_stream.sv
// Streaming line buffer: turns a raster-order square image into a MAXFIL x MAXFIL
// sliding window whose active size (fil_size) and image size are chosen per frame.
module linebuf_stream #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 10,
    parameter int MAXFIL = 5,
    parameter int ADDRW  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            buf_en,
    input  logic [LWIDTH-1:0]               img_size,
    input  logic [LWIDTH-1:0]               fil_size,
    input  logic signed [DWIDTH-1:0]        buf_input,
    input  logic                            in_valid,
    output logic [MAXFIL*MAXFIL*DWIDTH-1:0] buf_output,
    output logic                            out_valid,
    output logic                            done,
    output logic                            cfg_err
);

    localparam int NMEM = (MAXFIL > 1) ? MAXFIL - 1 : 1;
    localparam int SELW = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam logic [LWIDTH:0]   IMG_MAX = (LWIDTH + 1)'(2 ** ADDRW);
    localparam logic [LWIDTH-1:0] FIL_MAX = LWIDTH'(MAXFIL);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t            state, state_nxt;
    logic [LWIDTH-1:0] img_q, fil_q;
    logic [LWIDTH-1:0] col, row;
    logic [SELW-1:0]   wr_sel;
    logic              flush_cnt;

    logic              cfg_ok, start, accept, line_end, last_pix, sel_wrap, win_ok;
    logic              mem_en;
    logic [ADDRW-1:0]  addr;
    int                fil_n;

    // stage-1 pipeline: memory read data lines up with these
    logic              acc_d1, ok_d1;
    logic [DWIDTH-1:0] pix_d1;
    logic [SELW-1:0]   sel_d1;

    logic [DWIDTH-1:0] rd_data [NMEM];
    logic [DWIDTH-1:0] col_new [MAXFIL];
    logic [DWIDTH-1:0] win     [MAXFIL][MAXFIL];

    assign fil_n    = int'(fil_q);
    assign cfg_ok   = (fil_size != '0) && (fil_size <= FIL_MAX) &&
                      (img_size != '0) && ({1'b0, img_size} <= IMG_MAX) &&
                      (fil_size <= img_size);
    assign start    = (state == IDLE) && buf_en && cfg_ok;
    assign accept   = (state == RUN) && in_valid;
    assign line_end = (col == img_q - LWIDTH'(1));
    assign last_pix = line_end && (row == img_q - LWIDTH'(1));
    assign sel_wrap = (fil_q <= LWIDTH'(2)) || (LWIDTH'(wr_sel) >= fil_q - LWIDTH'(2));
    assign win_ok   = (row >= fil_q - LWIDTH'(1)) && (col >= fil_q - LWIDTH'(1));
    assign mem_en   = accept && (fil_q > LWIDTH'(1));
    assign addr     = col[ADDRW-1:0];

    // ---------------------------------------------------------------- control FSM
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (accept && last_pix) state_nxt = FLUSH;
            FLUSH: begin
                if (flush_cnt) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            img_q     <= '0;
            fil_q     <= '0;
            col       <= '0;
            row       <= '0;
            wr_sel    <= '0;
            flush_cnt <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_err   <= (state == IDLE) && buf_en && !cfg_ok;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (start) begin
                img_q  <= img_size;
                fil_q  <= fil_size;
                col    <= '0;
                row    <= '0;
                wr_sel <= '0;
            end else if (accept) begin
                if (line_end) begin
                    col    <= '0;
                    row    <= row + LWIDTH'(1);
                    wr_sel <= sel_wrap ? '0 : wr_sel + SELW'(1);
                end else begin
                    col <= col + LWIDTH'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- line memories
    // Each memory holds one earlier row; the one being overwritten is read first,
    // so all fil_size-1 previous rows at this column come back together.
    for (genvar k = 0; k < NMEM; k++) begin : g_mem
        logic [DWIDTH-1:0] mem [2**ADDRW];
        logic [DWIDTH-1:0] rd_q;

        // NOTE: memory contents are deliberately not reset; a reset would force
        // registers instead of RAM, and rows from older frames never reach a valid window.
        always_ff @(posedge clk) begin
            if (mem_en) begin
                rd_q <= mem[addr];
                if (wr_sel == SELW'(k)) mem[addr] <= buf_input;
            end
        end

        assign rd_data[k] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_d1 <= 1'b0;
            ok_d1  <= 1'b0;
        end else begin
            acc_d1 <= accept;
            ok_d1  <= accept && win_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_d1 <= buf_input;
            sel_d1 <= wr_sel;
        end
    end

    // Oldest row i lives in memory (sel + i) mod (fil_size-1); the newest row is the pixel.
    always_comb begin
        for (int i = 0; i < MAXFIL; i++) begin
            col_new[i] = '0;
            if (i < fil_n - 1) begin
                for (int k = 0; k < NMEM; k++) begin
                    if (k == rot_idx(int'(sel_d1), i, fil_n)) col_new[i] = rd_data[k];
                end
            end else if (i == fil_n - 1) begin
                col_new[i] = pix_d1;
            end
        end
    end

    function automatic int rot_idx(input int sel, input int i, input int f);
        int s;
        s = sel + i;
        return (s >= f - 1) ? s - (f - 1) : s;
    endfunction

    // ---------------------------------------------------------------- window
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int i = 0; i < MAXFIL; i++)
                for (int j = 0; j < MAXFIL; j++)
                    win[i][j] <= '0;
        end else begin
            out_valid <= acc_d1 && ok_d1;
            if (acc_d1) begin
                for (int i = 0; i < MAXFIL; i++) begin
                    for (int j = 0; j < MAXFIL - 1; j++) begin
                        if (i >= fil_n || j >= fil_n) win[i][j] <= '0;
                        else if (j < fil_n - 1)      win[i][j] <= win[i][j+1];
                        else                         win[i][j] <= col_new[i];
                    end
                    win[i][MAXFIL-1] <= (i < fil_n && fil_n == MAXFIL) ? col_new[i] : '0;
                end
            end
        end
    end

    always_comb begin
        buf_output = '0;
        for (int i = 0; i < MAXFIL; i++)
            for (int j = 0; j < MAXFIL; j++)
                buf_output[(i*MAXFIL+j)*DWIDTH +: DWIDTH] = win[i][j];
    end

endmodule

// File: tb/tb_linebuf_stream.sv
// Directed bench for linebuf_stream: frames with a window model and scoreboard,
// stalls, filter size 1, configuration errors and mid-frame reset.
module tb_linebuf_stream;

    localparam int DW = 16;
    localparam int LW = 10;
    localparam int MF = 5;
    localparam int AW = 8;
    localparam int WW = MF * MF * DW;

    logic                 clk, rst, buf_en, in_valid;
    logic [LW-1:0]        img_size, fil_size;
    logic signed [DW-1:0] buf_input;
    logic [WW-1:0]        buf_output;
    logic                 out_valid, done, cfg_err;

    linebuf_stream #(.DWIDTH(DW), .LWIDTH(LW), .MAXFIL(MF), .ADDRW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_en    (buf_en),
        .img_size  (img_size),
        .fil_size  (fil_size),
        .buf_input (buf_input),
        .in_valid  (in_valid),
        .buf_output(buf_output),
        .out_valid (out_valid),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    int            n_chk = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            ov_stray = 0;
    int            n_seen = 0;
    int            first_cyc = -1;
    bit            feeding = 0;
    bit            acc_prev = 0;
    bit            a_now;
    logic [WW-1:0] first_win, last_win, w_exp;
    logic [WW-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pix(input int r, input int c, input int base);
        return base + r * 16 + c;
    endfunction

    function automatic logic [WW-1:0] model_win(input int r, input int c, input int f, input int base);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < f; i++)
            for (int j = 0; j < f; j++)
                w[(i*MF+j)*DW +: DW] = DW'(pix(r - f + 1 + i, c - f + 1 + j, base));
        return w;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int i, input int j);
        return w[(i*MF+j)*DW +: DW];
    endfunction

    // Scoreboard: every out_valid window must match the next expected window and
    // must follow an accepted pixel by exactly two edges.
    always @(posedge clk) begin
        a_now = in_valid && feeding;
        #1;
        if (out_valid === 1'b1) begin
            if (!acc_prev) ov_stray++;
            if (n_seen == 0) begin
                first_cyc = cyc;
                first_win = buf_output;
            end
            last_win = buf_output;
            n_seen++;
            if (exp_q.size() > 0) begin
                w_exp = exp_q.pop_front();
                check("window", buf_output, w_exp);
            end
        end
        acc_prev = a_now;
    end

    // abort_at >= 0: stop after that many accepted pixels and pulse reset.
    task automatic run_frame(input int img, input int f, input int base, input bit stall, input int abort_at);
        int n_exp, exp_first, n_pix, g;
        n_exp = 0;
        exp_first = -2;
        for (int r = 0; r < img; r++)
            for (int c = 0; c < img; c++)
                if (r >= f - 1 && c >= f - 1) begin
                    exp_q.push_back(model_win(r, c, f, base));
                    n_exp++;
                end
        n_seen = 0;
        first_cyc = -1;

        buf_en = 1'b1;
        img_size = LW'(img);
        fil_size = LW'(f);
        tick();
        buf_en = 1'b0;
        check("cfg_err_ok", WW'(cfg_err), WW'(0));
        feeding = 1'b1;

        n_pix = (abort_at >= 0) ? abort_at : img * img;
        for (int p = 0; p < n_pix; p++) begin
            if (stall) begin
                g = 0;
                while ($urandom_range(0, 1) == 1 && g < 4) begin
                    in_valid = 1'b0;
                    tick();
                    g++;
                end
            end
            in_valid = 1'b1;
            buf_input = DW'(pix(p / img, p % img, base));
            tick();
            in_valid = 1'b0;
            if (p / img == f - 1 && p % img == f - 1) exp_first = cyc + 1;
        end
        feeding = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1;
            tick();
            check("rst_buf_output", buf_output, '0);
            check("rst_out_valid", WW'(out_valid), WW'(0));
            check("rst_done", WW'(done), WW'(0));
            rst = 1'b0;
            exp_q.delete();
            return;
        end

        check("done_early", WW'(done), WW'(0));
        tick();
        check("done_pulse", WW'(done), WW'(1));
        tick();
        check("done_after", WW'(done), WW'(0));
        check("n_windows", WW'(n_seen), WW'(n_exp));
        check("latency", WW'(first_cyc), WW'(exp_first));
        check("queue_empty", WW'(exp_q.size()), WW'(0));
    endtask

    task automatic cfg_bad(input int img, input int f);
        buf_en = 1'b1;
        img_size = LW'(img);
        fil_size = LW'(f);
        in_valid = 1'b1;
        buf_input = 16'h0055;
        tick();
        buf_en = 1'b0;
        check("cfg_err_pulse", WW'(cfg_err), WW'(1));
        tick();
        check("cfg_err_clear", WW'(cfg_err), WW'(0));
        repeat (4) tick();
        in_valid = 1'b0;
        check("cfg_no_done", WW'(done), WW'(0));
        check("cfg_no_window", WW'(n_seen), WW'(0));
    endtask

    initial begin
        rst = 1'b1;
        buf_en = 1'b0;
        in_valid = 1'b0;
        img_size = '0;
        fil_size = '0;
        buf_input = '0;
        tick();
        tick();
        check("reset_buf_output", buf_output, '0);
        check("reset_out_valid", WW'(out_valid), WW'(0));
        check("reset_done", WW'(done), WW'(0));
        check("reset_cfg_err", WW'(cfg_err), WW'(0));
        rst = 1'b0;
        tick();

        // 8x8, 3x3 filter, no stalls
        run_frame(8, 3, 0, 1'b0, -1);
        check("s1_e00", WW'(elem(first_win, 0, 0)), WW'(16'h00));
        check("s1_e02", WW'(elem(first_win, 0, 2)), WW'(16'h02));
        check("s1_e11", WW'(elem(first_win, 1, 1)), WW'(16'h11));
        check("s1_e20", WW'(elem(first_win, 2, 0)), WW'(16'h20));
        check("s1_e22", WW'(elem(first_win, 2, 2)), WW'(16'h22));
        check("s1_e03", WW'(elem(first_win, 0, 3)), WW'(16'h00));
        check("s1_e41", WW'(elem(first_win, 4, 1)), WW'(16'h00));
        check("s1_last_e22", WW'(elem(last_win, 2, 2)), WW'(16'h77));

        // back-to-back: 6x6, full 5x5 filter
        run_frame(6, 5, 0, 1'b0, -1);
        check("s2_first_e44", WW'(elem(first_win, 4, 4)), WW'(16'h44));
        check("s2_first_e00", WW'(elem(first_win, 0, 0)), WW'(16'h00));
        check("s2_last_e00", WW'(elem(last_win, 0, 0)), WW'(16'h11));
        check("s2_last_e44", WW'(elem(last_win, 4, 4)), WW'(16'h55));

        // scenario 1 again with random stalls
        run_frame(8, 3, 0, 1'b1, -1);
        check("s3_stall_ov", WW'(ov_stray), WW'(0));

        // filter size 1
        run_frame(4, 1, 0, 1'b0, -1);
        check("s4_last_e00", WW'(elem(last_win, 0, 0)), WW'(16'h33));
        check("s4_last_e01", WW'(elem(last_win, 0, 1)), WW'(16'h00));

        // rejected configurations, then a normal frame
        n_seen = 0;
        cfg_bad(257, 3);
        cfg_bad(8, 0);
        cfg_bad(8, 6);
        cfg_bad(2, 3);
        run_frame(4, 2, 16'h30, 1'b0, -1);
        check("s5_last_e11", WW'(elem(last_win, 1, 1)), WW'(16'h63));

        // reset at row 3, then a fresh frame with different pixel values
        run_frame(8, 3, 0, 1'b0, 3 * 8 + 2);
        tick();
        run_frame(8, 3, 16'h80, 1'b0, -1);
        check("s6_first_e00", WW'(elem(first_win, 0, 0)), WW'(16'h80));
        check("s6_first_e22", WW'(elem(first_win, 2, 2)), WW'(16'ha2));

        check("stray_out_valid", WW'(ov_stray), WW'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
